// File: rtl/storage_bank.sv
// Multi-channel enable-gated storage bank with flip-flop/transparent read mode and a
// snapshot engine that streams frozen words over valid/ready. Option: STORAGE_BANK_PARITY_EN.
module storage_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned ChW     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      mode,
  output logic [CHANNELS*WIDTH-1:0] q,
  input  logic                      snap,
  output logic                      busy,
  output logic                      snap_drop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [ChW-1:0]            out_ch,
`ifdef STORAGE_BANK_PARITY_EN
  output logic                      out_parity,
  input  logic                      parity_inject,
`endif
  output logic                      out_last
);

  localparam logic [ChW-1:0] LastIdx = ChW'(CHANNELS - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e           state_q;
  logic [ChW-1:0]   idx_q;
  logic             snap_drop_q;
  logic [WIDTH-1:0] s_q      [CHANNELS];
  logic [WIDTH-1:0] shadow_q [CHANNELS];
`ifdef STORAGE_BANK_PARITY_EN
  logic [CHANNELS-1:0] shadow_par_q;
`endif

  // Storage words: written on the edge whenever enabled, regardless of mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) s_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (en[c]) s_q[c] <= d[c*WIDTH +: WIDTH];
      end
    end
  end

  // Transparent mode is a combinational bypass around the stored word.
  always_comb begin
    q = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      q[c*WIDTH +: WIDTH] = (mode && en[c]) ? d[c*WIDTH +: WIDTH] : s_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      snap_drop_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) shadow_q[c] <= '0;
`ifdef STORAGE_BANK_PARITY_EN
      shadow_par_q <= '0;
`endif
    end else begin
      snap_drop_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (snap) begin
            // Capture pre-edge storage, not the data being written on this edge.
            for (int c = 0; c < CHANNELS; c++) begin
              shadow_q[c] <= s_q[c];
`ifdef STORAGE_BANK_PARITY_EN
              shadow_par_q[c] <= (^s_q[c]) ^ parity_inject;
`endif
            end
            idx_q   <= '0;
            state_q <= StStream;
          end
        end
        StStream: begin
          snap_drop_q <= snap;
          if (out_ready) begin
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StStream);
  assign out_valid = busy;
  assign out_data  = shadow_q[idx_q];
  assign out_ch    = idx_q;
  assign out_last  = busy && (idx_q == LastIdx);
  assign snap_drop = snap_drop_q;
`ifdef STORAGE_BANK_PARITY_EN
  assign out_parity = shadow_par_q[idx_q];
`endif

endmodule

// File: tb/tb_storage_bank.sv
// Directed self-checking bench for storage_bank (WIDTH=8, CHANNELS=4).
module tb_storage_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d;
  logic [3:0]  en;
  logic        mode;
  logic [31:0] q;
  logic        snap;
  logic        busy;
  logic        snap_drop;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_last;
`ifdef STORAGE_BANK_PARITY_EN
  logic        out_parity;
  logic        parity_inject;
`endif

  int compared   = 0;
  int mismatched = 0;

  storage_bank #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .en        (en),
    .mode      (mode),
    .q         (q),
    .snap      (snap),
    .busy      (busy),
    .snap_drop (snap_drop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
`ifdef STORAGE_BANK_PARITY_EN
    .out_parity    (out_parity),
    .parity_inject (parity_inject),
`endif
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] data, input logic [1:0] ch,
                          input logic last);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, data});
    chk({tag, "_ch"}, {30'd0, out_ch}, {30'd0, ch});
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  initial begin
    rst_n = 1'b0; d = '0; en = '0; mode = 1'b0; snap = 1'b0; out_ready = 1'b0;
`ifdef STORAGE_BANK_PARITY_EN
    parity_inject = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_q", q, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_drop", {31'd0, snap_drop}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);

    // Mode 0 write then hold
    en = 4'b0001; d = 32'h0000_00A5;
    #1;
    chk("m0_pre_edge", q, 32'h0);
    tick();
    chk("m0_write", q, 32'h0000_00A5);
    en = 4'b0000; d = 32'h0000_003C;
    tick();
    chk("m0_hold", q, 32'h0000_00A5);

    // Mode 1 transparency
    mode = 1'b1; en = 4'b0010; d = 32'h0000_5A00;
    #1;
    chk("m1_bypass", q, 32'h0000_5AA5);
    tick();
    en = 4'b0000; d = 32'h0000_FF00;
    #1;
    chk("m1_hold", q, 32'h0000_5AA5);
    mode = 1'b0;

    // Load all channels and stream with ready high
    en = 4'b1111; d = 32'h4433_2211;
    tick();
    en = 4'b0000; d = '0;
    chk("load", q, 32'h4433_2211);
    snap = 1'b1;
    tick();
    snap = 1'b0; out_ready = 1'b1;
    chk_beat("s1_b0", 8'h11, 2'd0, 1'b0);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk_beat("s1_b1", 8'h22, 2'd1, 1'b0);
    tick();
    chk_beat("s1_b2", 8'h33, 2'd2, 1'b0);
    tick();
    chk_beat("s1_b3", 8'h44, 2'd3, 1'b1);
    tick();
    chk("s1_busy_end", {31'd0, busy}, 32'd0);
    chk("s1_valid_end", {31'd0, out_valid}, 32'd0);

    // Backpressure on beat 2 with a write to ch2 during the stall
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk_beat("s2_b0", 8'h11, 2'd0, 1'b0);
    tick();
    chk_beat("s2_b1", 8'h22, 2'd1, 1'b0);
    tick();
    out_ready = 1'b0; en = 4'b0100; d = 32'h0099_0000;
    for (int i = 0; i < 3; i++) begin
      chk_beat("s2_stall", 8'h33, 2'd2, 1'b0);
      tick();
      en = 4'b0000;
    end
    chk("s2_ch2_written", q, 32'h4499_2211);
    out_ready = 1'b1;
    chk_beat("s2_b2", 8'h33, 2'd2, 1'b0);
    tick();
    chk_beat("s2_b3", 8'h44, 2'd3, 1'b1);
    tick();
    chk("s2_busy_end", {31'd0, busy}, 32'd0);

    // Capture uses pre-edge storage; mid-stream snap is dropped
    snap = 1'b1; en = 4'b0001; d = 32'h0000_00EE;
    tick();
    snap = 1'b0; en = 4'b0000; d = '0;
    chk("s3_ch0_written", q, 32'h4499_22EE);
    chk_beat("s3_b0", 8'h11, 2'd0, 1'b0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("s3_drop", {31'd0, snap_drop}, 32'd1);
    chk_beat("s3_b1", 8'h22, 2'd1, 1'b0);
    tick();
    chk("s3_drop_clr", {31'd0, snap_drop}, 32'd0);
    chk_beat("s3_b2", 8'h99, 2'd2, 1'b0);
    tick();
    chk_beat("s3_b3", 8'h44, 2'd3, 1'b1);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("s3_final_snap_busy", {31'd0, busy}, 32'd0);
    chk("s3_final_snap_drop", {31'd0, snap_drop}, 32'd1);
    tick();
    chk("s3_no_restart", {31'd0, out_valid}, 32'd0);
    chk("s3_drop_done", {31'd0, snap_drop}, 32'd0);

    // Reset mid-stream
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk_beat("s4_b0", 8'hEE, 2'd0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s4_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("s4_rst_busy", {31'd0, busy}, 32'd0);
    chk("s4_rst_last", {31'd0, out_last}, 32'd0);
    chk("s4_rst_q", q, 32'h0);
    tick();
    chk("s4_stays_idle", {31'd0, out_valid}, 32'd0);

`ifdef STORAGE_BANK_PARITY_EN
    en = 4'b0001; d = 32'h0000_0007;
    tick();
    en = 4'b0000; d = '0; out_ready = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("par_ch0", {31'd0, out_parity}, 32'd1);
    tick();
    chk("par_held", {31'd0, out_parity}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("par_ch1", {31'd0, out_parity}, 32'd0);
    tick();
    tick();
    tick();
    parity_inject = 1'b1; snap = 1'b1;
    tick();
    parity_inject = 1'b0; snap = 1'b0;
    chk("par_inj_ch0", {31'd0, out_parity}, 32'd0);
    tick();
    chk("par_inj_ch1", {31'd0, out_parity}, 32'd1);
    tick();
    tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
